// File: rtl/tristate_bus_driver.sv
// Tri-state bus driver: moves bursts of words from one of CHANNELS inputs
// onto a shared bus, with a one-cycle high-Z turnaround after each burst.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   din        CHANNELS packed words, channel i at [i*WIDTH +: WIDTH]
//   req_valid  burst request
//   req_sel    requested channel
//   req_len    burst length in beats (0 means 1)
//   req_ready  request can be accepted this cycle
//   abort      ends the active burst early
//   bus_out    shared bus, high-Z when not driving
//   bus_oe     high exactly while bus_out is driven
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse in the turnaround cycle after a burst
//   err        one-cycle pulse after a request for a missing channel
module tristate_bus_driver #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int LEN_W    = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      req_valid,
    input  logic [SEL_W-1:0]          req_sel,
    input  logic [LEN_W-1:0]          req_len,
    output logic                      req_ready,
    input  logic                      abort,
    output tri   [WIDTH-1:0]          bus_out,
    output logic                      bus_oe,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] cnt;
    logic             oe_q;
    logic             done_q;
    logic             err_q;

    logic [31:0]      req_sel_ext;
    logic [31:0]      sel_q_ext;
    logic             sel_ok;
    logic [WIDTH-1:0] req_word;
    logic [WIDTH-1:0] hold_word;
    logic [LEN_W-1:0] first_cnt;

    // Widen selects so the range check is not a constant compare when
    // CHANNELS is a power of two.
    assign req_sel_ext = 32'(req_sel);
    assign sel_q_ext   = 32'(sel_q);
    assign sel_ok      = req_sel_ext < 32'(CHANNELS);

    // Channel muxes; an out-of-range select yields zero instead of
    // reaching past the end of din.
    always_comb begin
        req_word  = '0;
        hold_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (req_sel_ext == 32'(i)) begin
                req_word = din[i*WIDTH +: WIDTH];
            end
            if (sel_q_ext == 32'(i)) begin
                hold_word = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // The counter holds beats remaining after the current one.
    assign first_cnt = (req_len == '0) ? '0 : req_len - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sel_q  <= '0;
            data_q <= '0;
            cnt    <= '0;
            oe_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (sel_ok) begin
                            sel_q  <= req_sel;
                            data_q <= req_word;
                            cnt    <= first_cnt;
                            oe_q   <= 1'b1;
                            state  <= DRIVE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (abort || cnt == '0) begin
                        cnt    <= '0;
                        oe_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= TURN;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        data_q <= hold_word;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    oe_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus_out   = oe_q ? data_q : {WIDTH{1'bz}};
    assign bus_oe    = oe_q;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign req_ready = (state == IDLE) && !reset;

endmodule

// File: tb/tb_tristate_bus_driver.sv
// Directed bench for tristate_bus_driver: a 4-channel and a 3-channel
// instance, one task per scenario, status compared after each edge.
module tb_tristate_bus_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din4;
    logic        valid4;
    logic [1:0]  sel4;
    logic [3:0]  len4;
    logic        abort4;
    logic        ready4;
    wire  [7:0]  bus4;
    logic        oe4, busy4, done4, err4;

    logic [23:0] din3;
    logic        valid3;
    logic [1:0]  sel3;
    logic [3:0]  len3;
    logic        abort3;
    logic        ready3;
    wire  [7:0]  bus3;
    logic        oe3, busy3, done3, err3;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    tristate_bus_driver #(.WIDTH(8), .CHANNELS(4), .LEN_W(4)) dut4 (
        .clk(clk), .reset(reset), .din(din4),
        .req_valid(valid4), .req_sel(sel4), .req_len(len4),
        .req_ready(ready4), .abort(abort4), .bus_out(bus4),
        .bus_oe(oe4), .busy(busy4), .done(done4), .err(err4)
    );

    tristate_bus_driver #(.WIDTH(8), .CHANNELS(3), .LEN_W(4)) dut3 (
        .clk(clk), .reset(reset), .din(din3),
        .req_valid(valid3), .req_sel(sel3), .req_len(len3),
        .req_ready(ready3), .abort(abort3), .bus_out(bus3),
        .bus_oe(oe3), .busy(busy3), .done(done3), .err(err3)
    );

    // Status vectors are {bus_oe, busy, done, err, req_ready}.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b00000)
            $display("FAIL reset4 got %b want 00000",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
        total++;
        if ({oe3, busy3, done3, err3, ready3} !== 5'b00000)
            $display("FAIL reset3 got %b want 00000",
                     {oe3, busy3, done3, err3, ready3});
        else pass_cnt++;
        reset = 1'b0;
        step();
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b00001)
            $display("FAIL idle_after_reset got %b want 00001",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
    endtask

    task automatic test_burst3();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h10;
        exp_d[1] = 8'h11;
        exp_d[2] = 8'h12;
        valid4 = 1'b1;
        sel4   = 2'd2;
        len4   = 4'd3;
        din4   = 32'h00_10_00_00;
        for (int b = 0; b < 3; b++) begin
            step();
            valid4 = 1'b0;
            total++;
            if ({oe4, busy4, done4, ready4} !== 4'b1100 || bus4 !== exp_d[b])
                $display("FAIL burst3_beat%0d got st=%b bus=%h want st=1100 bus=%h",
                         b, {oe4, busy4, done4, ready4}, bus4, exp_d[b]);
            else pass_cnt++;
            if (b < 2) din4[23:16] = exp_d[b+1];
        end
        din4 = 32'h00_ee_00_00;
        step();
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b01100)
            $display("FAIL burst3_turn got %b want 01100",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
        step();
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b00001)
            $display("FAIL burst3_idle got %b want 00001",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        valid4 = 1'b1;
        sel4   = 2'd1;
        len4   = 4'd0;
        din4   = 32'h00_00_a5_00;
        step();
        valid4 = 1'b0;
        din4   = 32'h00_00_5a_00;
        total++;
        if (oe4 !== 1'b1 || bus4 !== 8'ha5)
            $display("FAIL len0_beat got oe=%b bus=%h want oe=1 bus=a5",
                     oe4, bus4);
        else pass_cnt++;
        step();
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b01100)
            $display("FAIL len0_turn got %b want 01100",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
        step();
    endtask

    task automatic test_reject();
        logic [4:0] exp_st [3];
        exp_st[0] = 5'b00011;
        exp_st[1] = 5'b00001;
        exp_st[2] = 5'b00001;
        valid3 = 1'b1;
        sel3   = 2'd3;
        len3   = 4'd2;
        din3   = 24'h33_22_11;
        for (int c = 0; c < 3; c++) begin
            step();
            valid3 = 1'b0;
            total++;
            if ({oe3, busy3, done3, err3, ready3} !== exp_st[c])
                $display("FAIL reject_cyc%0d got %b want %b", c,
                         {oe3, busy3, done3, err3, ready3}, exp_st[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        valid4 = 1'b1;
        sel4   = 2'd0;
        len4   = 4'd8;
        din4   = 32'h00_00_00_20;
        for (int b = 0; b < 3; b++) begin
            step();
            valid4 = 1'b0;
            total++;
            if (oe4 !== 1'b1 || done4 !== 1'b0 || bus4 !== 8'(8'h20 + b))
                $display("FAIL abort_beat%0d got oe=%b done=%b bus=%h want 1 0 %h",
                         b, oe4, done4, bus4, 8'(8'h20 + b));
            else pass_cnt++;
            din4[7:0] = 8'(8'h21 + b);
            if (b == 2) abort4 = 1'b1;
        end
        step();
        abort4 = 1'b0;
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b01100)
            $display("FAIL abort_turn got %b want 01100",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
        step();
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b00001)
            $display("FAIL abort_idle got %b want 00001",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        int saw_done;
        saw_done = 0;
        valid4 = 1'b1;
        sel4   = 2'd3;
        len4   = 4'd5;
        din4   = 32'h44_00_00_00;
        step();
        valid4 = 1'b0;
        step();
        total++;
        if (oe4 !== 1'b1 || bus4 !== 8'h44)
            $display("FAIL rst_mid_drive got oe=%b bus=%h want 1 44", oe4, bus4);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total++;
        if (ready4 !== 1'b0)
            $display("FAIL rst_ready got %b want 0", ready4);
        else pass_cnt++;
        step();
        total++;
        if ({oe4, busy4, done4, err4, ready4} !== 5'b00000)
            $display("FAIL rst_mid_state got %b want 00000",
                     {oe4, busy4, done4, err4, ready4});
        else pass_cnt++;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done4 || oe4) saw_done++;
        end
        total++;
        if (saw_done !== 0 || ready4 !== 1'b1)
            $display("FAIL rst_no_done got done_or_oe=%0d ready=%b want 0 1",
                     saw_done, ready4);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_st [8];
        exp_st[0] = 5'b11000;
        exp_st[1] = 5'b11000;
        exp_st[2] = 5'b01100;
        exp_st[3] = 5'b00001;
        exp_st[4] = 5'b11000;
        exp_st[5] = 5'b11000;
        exp_st[6] = 5'b01100;
        exp_st[7] = 5'b00001;
        valid4 = 1'b1;
        sel4   = 2'd3;
        len4   = 4'd2;
        din4   = 32'h3c_00_00_00;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 6) valid4 = 1'b0;
            total++;
            if ({oe4, busy4, done4, err4, ready4} !== exp_st[c] ||
                (oe4 === 1'b1 && bus4 !== 8'h3c))
                $display("FAIL b2b_cyc%0d got st=%b bus=%h want st=%b bus=3c",
                         c, {oe4, busy4, done4, err4, ready4}, bus4, exp_st[c]);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        din4   = '0;
        valid4 = 1'b0;
        sel4   = '0;
        len4   = '0;
        abort4 = 1'b0;
        din3   = '0;
        valid3 = 1'b0;
        sel3   = '0;
        len3   = '0;
        abort3 = 1'b0;
        #2;
        test_reset();
        test_burst3();
        test_len_zero();
        test_reject();
        test_abort();
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/tristate_bus_driver.md
TRISTATE_BUS_DRIVER -- requirements
Module: tristate_bus_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width per channel and the bus width (1..32).
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of input channels (2..16; a power of two is not required).
REQ-003 The block SHALL have parameter LEN_W, default 4, giving the width of the burst-length field.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge only.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port din, input, CHANNELS*WIDTH bits: channel i SHALL occupy bits [i*WIDTH +: WIDTH].
REQ-007 Port req_valid, input, 1 bit: burst request.
REQ-008 Port req_sel, input, SEL_W = max(1, clog2(CHANNELS)) bits: requested channel.
REQ-009 Port req_len, input, LEN_W bits: number of beats requested.
REQ-010 Port req_ready, output, 1 bit: request can be accepted this cycle.
REQ-011 Port abort, input, 1 bit: terminates the active burst.
REQ-012 Port bus_out, tri-state output, WIDTH bits: shared bus, high-Z when not driving.
REQ-013 Port bus_oe, output, 1 bit: high exactly when bus_out is driven.
REQ-014 Port busy, output, 1 bit: high when the state is not IDLE.
REQ-015 Port done, output, 1 bit: single-cycle pulse at burst end.
REQ-016 Port err, output, 1 bit: single-cycle pulse when a request is rejected.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE and TURN; req_ready SHALL be 1 only in IDLE and only when reset is low.
REQ-018 Acceptance: at an edge in IDLE with req_valid=1 and req_sel<CHANNELS, the block SHALL latch sel_q<=req_sel, load data_q<=din[req_sel], set the beat counter to max(req_len,1)-1, and go to DRIVE.
REQ-019 Rejection: at an edge in IDLE with req_valid=1 and req_sel>=CHANNELS, the block SHALL stay in IDLE and assert err for exactly the next cycle; bus_out SHALL stay high-Z.
REQ-020 req_len=0 SHALL be treated as a 1-beat burst; the maximum burst is 2^LEN_W-1 beats.
REQ-021 In DRIVE, bus_oe SHALL be 1 and bus_out SHALL equal data_q; bus_out SHALL be registered, with latency one edge from din sampling to the bus.
REQ-022 In DRIVE with the counter >0 and abort=0, each edge SHALL decrement the counter and reload data_q<=din[sel_q]; sel_q SHALL be held for the whole burst.
REQ-023 In DRIVE with the counter =0, the next edge SHALL go to TURN and assert done for the TURN cycle.
REQ-024 abort=1 at any edge in DRIVE SHALL go to TURN with done asserted and the remaining beats discarded; abort outside DRIVE SHALL be ignored.
REQ-025 TURN SHALL last exactly one cycle with bus_oe=0, bus_out high-Z and req_ready=0, then go to IDLE; back-to-back bursts therefore have a one-cycle high-Z gap.
REQ-026 The number of DRIVE cycles SHALL equal max(req_len,1), unless the burst is aborted.
REQ-027 bus_oe, busy, done and err SHALL be outputs of registered state with no combinational path from the inputs; req_ready SHALL depend only on the state and reset.

Reset
REQ-028 With reset=1 at an edge, the block SHALL go to IDLE, clear data_q, sel_q and the counter, and drive bus_oe=0, busy=0, done=0 and err=0, with bus_out high-Z from the next cycle.
REQ-029 Reset SHALL take priority over every other input, including in the middle of DRIVE or TURN; no done pulse SHALL be produced for the interrupted burst.
REQ-030 req_ready SHALL be 0 while reset=1.

Verification
REQ-031 The bench SHALL cover: WIDTH=8, CHANNELS=4, req_sel=2, req_len=3, channel 2 stepping 0x10,0x11,0x12 -> bus_oe high for 3 cycles, bus_out 0x10,0x11,0x12, then 1 TURN cycle with done=1 and Z.
REQ-032 The bench SHALL cover: req_len=0, req_sel=1, din[1]=0xA5 -> exactly 1 DRIVE cycle with bus_out=0xA5, then done.
REQ-033 The bench SHALL cover: CHANNELS=3, req_sel=3 -> err pulses for 1 cycle, busy stays 0 and bus_out stays Z throughout.
REQ-034 The bench SHALL cover: req_len=8 with abort asserted at the 3rd DRIVE cycle -> 3 driven beats, done in the following cycle, then IDLE.
REQ-035 The bench SHALL cover: reset asserted in the 2nd DRIVE cycle of a 5-beat burst -> the next cycle is IDLE with bus_oe=0, Z on the bus and done never asserted.
REQ-036 The bench SHALL cover: req_valid held high across two bursts (len=2 each) -> DRIVE,DRIVE,TURN,IDLE(accept),DRIVE,DRIVE,TURN, with no cycle in which bus_oe is high during TURN.
